mem_access_sequencer: RTL and testbench

Sequencer between the execute stage and `MemStage`. It accepts one instruction at a time from EX, holds all `MemStage` operands stable, and pulses `MemStage`'s reset so its read/write modules restart for each access. It waits for `mem_finished` (bounded by a timeout) and then retires a one-cycle write-back packet to the register-file write port. Non-memory instructions bypass memory and retire one cycle after acceptance.

---
 rtl/mem_access_sequencer_if.sv | 74 +++++++
 rtl/mem_access_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Bundle of every handshake and data signal around mem_access_sequencer:
// the EX-side offer, the MemStage operand/control bus, and the
// register-file write-back port.
// The master view belongs to the sequencer; the slave view belongs to the
// surrounding pipeline (EX stage, MemStage and register file).
interface mem_access_sequencer_if #(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 32,
    parameter int R = 5
);
    // EX stage offer
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_mem_req;
    logic             ex_write;
    logic [1:0]       ex_op_type;
    logic             ex_op_source;
    logic [A-1:0]     ex_address;
    logic [I*L-1:0]   ex_alu_v;
    logic [I*L-1:0]   ex_rd2_v;
    logic [L-1:0]     ex_alu_s;
    logic [L-1:0]     ex_rd2_s;
    logic             ex_wb_en;
    logic [R-1:0]     ex_wb_rd;

    // MemStage control, operands and result
    logic             mem_rst;
    logic [1:0]       mem_op_type;
    logic             mem_op_source;
    logic             mem_write_enable;
    logic [A-1:0]     mem_address;
    logic [I*L-1:0]   mem_alu_v;
    logic [I*L-1:0]   mem_rd2_v;
    logic [L-1:0]     mem_alu_s;
    logic [L-1:0]     mem_rd2_s;
    logic             mem_finished;
    logic [L-1:0]     mem_scalar;
    logic [I*L-1:0]   mem_vector;

    // Register-file write-back port and status
    logic             wb_valid;
    logic             wb_en;
    logic [R-1:0]     wb_rd;
    logic             wb_vec;
    logic [L-1:0]     wb_scalar;
    logic [I*L-1:0]   wb_vector;
    logic             wb_error;
    logic             err_timeout;

    modport master (
        input  ex_valid, ex_mem_req, ex_write, ex_op_type, ex_op_source,
               ex_address, ex_alu_v, ex_rd2_v, ex_alu_s, ex_rd2_s,
               ex_wb_en, ex_wb_rd,
        output ex_ready,
        output mem_rst, mem_op_type, mem_op_source, mem_write_enable,
               mem_address, mem_alu_v, mem_rd2_v, mem_alu_s, mem_rd2_s,
        input  mem_finished, mem_scalar, mem_vector,
        output wb_valid, wb_en, wb_rd, wb_vec, wb_scalar, wb_vector,
               wb_error, err_timeout
    );

    modport slave (
        output ex_valid, ex_mem_req, ex_write, ex_op_type, ex_op_source,
               ex_address, ex_alu_v, ex_rd2_v, ex_alu_s, ex_rd2_s,
               ex_wb_en, ex_wb_rd,
        input  ex_ready,
        input  mem_rst, mem_op_type, mem_op_source, mem_write_enable,
               mem_address, mem_alu_v, mem_rd2_v, mem_alu_s, mem_rd2_s,
        output mem_finished, mem_scalar, mem_vector,
        input  wb_valid, wb_en, wb_rd, wb_vec, wb_scalar, wb_vector,
               wb_error, err_timeout
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: single-issue sequencer between EX and MemStage.
// One instruction is captured into a holding register, MemStage gets a
// one-cycle reset pulse (CLEAR) so its read/write engines restart, then
// the sequencer waits in ACCESS for mem_finished (bounded by TIMEOUT) and
// retires a one-cycle write-back packet from DONE. Non-memory instructions
// skip MemStage and retire the cycle after acceptance.
module mem_access_sequencer #(
    parameter int I       = 20,
    parameter int L       = 8,
    parameter int A       = 32,
    parameter int R       = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_access_sequencer_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Last ACCESS cycle index: TIMEOUT cycles are counted 0 .. TIMEOUT-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [I*L-1:0] ZERO_V = {(I*L){1'b0}};
    localparam logic [L-1:0]   ZERO_S = {L{1'b0}};
    localparam logic [A-1:0]   ZERO_A = {A{1'b0}};
    localparam logic [R-1:0]   ZERO_R = {R{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Scalar result lane: only meaningful for scalar operations
    function automatic logic [L-1:0] sel_scalar(input logic is_vec, input logic [L-1:0] val);
        if (is_vec) begin
            return ZERO_S;
        end else begin
            return val;
        end
    endfunction

    // Vector result lane: only meaningful for vector operations
    function automatic logic [I*L-1:0] sel_vector(input logic is_vec, input logic [I*L-1:0] val);
        if (is_vec) begin
            return val;
        end else begin
            return ZERO_V;
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    // Holding register: MemStage operands stay stable until next acceptance
    logic [1:0]       op_type_r;
    logic             op_source_r;
    logic             mem_we_r;
    logic [A-1:0]     address_r;
    logic [I*L-1:0]   alu_v_r;
    logic [I*L-1:0]   rd2_v_r;
    logic [L-1:0]     alu_s_r;
    logic [L-1:0]     rd2_s_r;
    logic             hold_wb_en_r;
    logic [R-1:0]     hold_wb_rd_r;

    // Write-back packet (held between retires)
    logic             wb_valid_r;
    logic             wb_en_r;
    logic [R-1:0]     wb_rd_r;
    logic             wb_vec_r;
    logic [L-1:0]     wb_scalar_r;
    logic [I*L-1:0]   wb_vector_r;
    logic             wb_error_r;
    logic             err_timeout_r;

    // Packet that retires if the FSM leaves its current state this cycle
    logic             ret_en_s;
    logic [R-1:0]     ret_rd_s;
    logic             ret_vec_s;
    logic [L-1:0]     ret_scalar_s;
    logic [I*L-1:0]   ret_vector_s;
    logic             ret_err_s;
    logic             access_end_s;

    // Assemble the retire packet for a bypass (IDLE) or memory (ACCESS) exit
    always_comb begin
        ret_en_s     = 1'b0;
        ret_rd_s     = hold_wb_rd_r;
        ret_vec_s    = op_type_r[1];
        ret_scalar_s = ZERO_S;
        ret_vector_s = ZERO_V;
        ret_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ret_en_s     = bus.ex_wb_en;
                ret_rd_s     = bus.ex_wb_rd;
                ret_vec_s    = bus.ex_op_type[1];
                ret_scalar_s = sel_scalar(bus.ex_op_type[1], bus.ex_alu_s);
                ret_vector_s = sel_vector(bus.ex_op_type[1], bus.ex_alu_v);
            end
            ST_ACCESS: begin
                if (bus.mem_finished) begin
                    if (mem_we_r) begin
                        // Stores never write the register file
                        ret_en_s = 1'b0;
                    end else begin
                        ret_en_s     = hold_wb_en_r;
                        ret_scalar_s = sel_scalar(op_type_r[1], bus.mem_scalar);
                        ret_vector_s = sel_vector(op_type_r[1], bus.mem_vector);
                    end
                end else begin
                    // Only used when the counter has run out: abort with zero data
                    ret_err_s = 1'b1;
                end
            end
            default: begin
                ret_en_s = 1'b0;
            end
        endcase
    end

    // ACCESS ends on completion, or on the last permitted cycle without it
    always_comb begin
        if (state_r == ST_ACCESS) begin
            access_end_s = bus.mem_finished || (cnt_r == CNT_LAST);
        end else begin
            access_end_s = 1'b0;
        end
    end

    // Main sequencer FSM with holding register and registered write-back packet
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            op_type_r     <= 2'b00;
            op_source_r   <= 1'b0;
            mem_we_r      <= 1'b0;
            address_r     <= ZERO_A;
            alu_v_r       <= ZERO_V;
            rd2_v_r       <= ZERO_V;
            alu_s_r       <= ZERO_S;
            rd2_s_r       <= ZERO_S;
            hold_wb_en_r  <= 1'b0;
            hold_wb_rd_r  <= ZERO_R;
            wb_valid_r    <= 1'b0;
            wb_en_r       <= 1'b0;
            wb_rd_r       <= ZERO_R;
            wb_vec_r      <= 1'b0;
            wb_scalar_r   <= ZERO_S;
            wb_vector_r   <= ZERO_V;
            wb_error_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            wb_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // ex_ready is high whenever IDLE is not in reset
                    if (bus.ex_valid) begin
                        op_type_r    <= bus.ex_op_type;
                        op_source_r  <= bus.ex_op_source;
                        address_r    <= bus.ex_address;
                        alu_v_r      <= bus.ex_alu_v;
                        rd2_v_r      <= bus.ex_rd2_v;
                        alu_s_r      <= bus.ex_alu_s;
                        rd2_s_r      <= bus.ex_rd2_s;
                        hold_wb_en_r <= bus.ex_wb_en;
                        hold_wb_rd_r <= bus.ex_wb_rd;
                        if (bus.ex_mem_req) begin
                            mem_we_r <= bus.ex_write;
                            state_r  <= ST_CLEAR;
                        end else begin
                            mem_we_r    <= 1'b0;
                            wb_valid_r  <= 1'b1;
                            wb_en_r     <= ret_en_s;
                            wb_rd_r     <= ret_rd_s;
                            wb_vec_r    <= ret_vec_s;
                            wb_scalar_r <= ret_scalar_s;
                            wb_vector_r <= ret_vector_s;
                            wb_error_r  <= ret_err_s;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    // mem_finished may be stale here and is deliberately ignored
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_end_s) begin
                        mem_we_r    <= 1'b0;
                        wb_valid_r  <= 1'b1;
                        wb_en_r     <= ret_en_s;
                        wb_rd_r     <= ret_rd_s;
                        wb_vec_r    <= ret_vec_s;
                        wb_scalar_r <= ret_scalar_s;
                        wb_vector_r <= ret_vector_s;
                        wb_error_r  <= ret_err_s;
                        if (ret_err_s) begin
                            err_timeout_r <= 1'b1;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Acceptance window and MemStage reset follow reset directly
    assign bus.ex_ready         = (state_r == ST_IDLE) && !rst;
    assign bus.mem_rst          = rst || (state_r == ST_CLEAR);

    assign bus.mem_op_type      = op_type_r;
    assign bus.mem_op_source    = op_source_r;
    assign bus.mem_write_enable = mem_we_r;
    assign bus.mem_address      = address_r;
    assign bus.mem_alu_v        = alu_v_r;
    assign bus.mem_rd2_v        = rd2_v_r;
    assign bus.mem_alu_s        = alu_s_r;
    assign bus.mem_rd2_s        = rd2_s_r;

    assign bus.wb_valid         = wb_valid_r;
    assign bus.wb_en            = wb_en_r;
    assign bus.wb_rd            = wb_rd_r;
    assign bus.wb_vec           = wb_vec_r;
    assign bus.wb_scalar        = wb_scalar_r;
    assign bus.wb_vector        = wb_vector_r;
    assign bus.wb_error         = wb_error_r;
    assign bus.err_timeout      = err_timeout_r;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a driver issues directed and
// random instructions (and plays MemStage), pushing the expected retire
// packet computed from the instruction-level rules; a monitor pops and
// compares whenever wb_valid is seen.
module tb_mem_access_sequencer;
    localparam int I = 20;
    localparam int L = 8;
    localparam int A = 32;
    localparam int R = 5;
    localparam int TIMEOUT = 24;
    localparam int W = I * L;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_sequencer_if #(.I(I), .L(L), .A(A), .R(R)) bus();

    mem_access_sequencer #(.I(I), .L(L), .A(A), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic           mem_req;
        logic           write;
        logic [1:0]     op;
        logic           src;
        logic [A-1:0]   addr;
        logic [W-1:0]   alu_v;
        logic [W-1:0]   rd2_v;
        logic [W-1:0]   mv;
        logic [L-1:0]   alu_s;
        logic [L-1:0]   rd2_s;
        logic [L-1:0]   ms;
        logic           wb_en;
        logic [R-1:0]   rd;
        int             d;      // ACCESS cycle carrying mem_finished; 0 = never
        bit             stale;  // mem_finished also high before ACCESS
    } instr_t;

    typedef struct {
        int             cyc;
        logic           en;
        logic [R-1:0]   rd;
        logic           vec;
        logic [L-1:0]   s;
        logic [W-1:0]   v;
        logic           err;
    } exp_t;

    exp_t sb_q[$];
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < (W + 31) / 32; k++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    // Expected retire, from the instruction-level rules only
    function automatic exp_t model(input instr_t x, input int t);
        exp_t e;
        e.rd = x.rd; e.vec = x.op[1]; e.err = 1'b0; e.en = 1'b0;
        e.s = '0; e.v = '0;
        if (!x.mem_req) begin
            e.cyc = t + 1;
            e.en  = x.wb_en;
            if (x.op[1]) e.v = x.alu_v; else e.s = x.alu_s;
        end else if (x.d == 0) begin
            e.cyc = t + 2 + TIMEOUT;
            e.err = 1'b1;
        end else begin
            e.cyc = t + 2 + x.d;
            if (!x.write) begin
                e.en = x.wb_en;
                if (x.op[1]) e.v = x.mv; else e.s = x.ms;
            end
        end
        return e;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int sel;
        x.mem_req = 1'($urandom_range(0, 1));
        x.write   = 1'($urandom_range(0, 1));
        x.op      = 2'($urandom_range(0, 3));
        x.src     = 1'($urandom_range(0, 1));
        x.addr    = A'($urandom);
        x.alu_v   = rand_w();
        x.rd2_v   = rand_w();
        x.mv      = rand_w();
        x.alu_s   = L'($urandom);
        x.rd2_s   = L'($urandom);
        x.ms      = L'($urandom);
        x.wb_en   = 1'($urandom_range(0, 1));
        x.rd      = R'($urandom);
        sel = $urandom_range(0, 9);
        x.d = (sel == 0) ? 0 : ((sel == 1) ? TIMEOUT : $urandom_range(1, TIMEOUT));
        x.stale = (x.d == 1) && ($urandom_range(0, 1) == 1);
        return x;
    endfunction

    task automatic drive_ex(input instr_t x);
        bus.ex_mem_req   = x.mem_req;
        bus.ex_write     = x.write;
        bus.ex_op_type   = x.op;
        bus.ex_op_source = x.src;
        bus.ex_address   = x.addr;
        bus.ex_alu_v     = x.alu_v;
        bus.ex_rd2_v     = x.rd2_v;
        bus.ex_alu_s     = x.alu_s;
        bus.ex_rd2_s     = x.rd2_s;
        bus.ex_wb_en     = x.wb_en;
        bus.ex_wb_rd     = x.rd;
    endtask

    task automatic wait_ready(output bit ok);
        int waitn;
        waitn = 0;
        while (bus.ex_ready !== 1'b1 && waitn < 100) begin
            @(negedge clk);
            waitn++;
        end
        chk("ex_ready_wait", W'(bus.ex_ready), W'(1'b1));
        ok = (bus.ex_ready === 1'b1);
    endtask

    // Issue one instruction, play MemStage, and check the in-flight window
    task automatic issue(input instr_t x);
        int t, last;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        t = cyc;
        drive_ex(x);
        bus.ex_valid     = 1'b1;
        bus.mem_finished = x.mem_req && x.stale;
        sb_q.push_back(model(x, t));
        if (x.mem_req && x.d == 0) exp_err = 1'b1;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        drive_ex(rand_instr());
        if (x.mem_req) begin
            last = (x.d == 0) ? t + 1 + TIMEOUT : t + 1 + x.d;
            for (int c = t + 1; c <= last; c++) begin
                chk("mem_rst", W'(bus.mem_rst), W'(c == t + 1));
                chk("mem_write_enable", W'(bus.mem_write_enable), W'(x.write));
                chk("mem_address", W'(bus.mem_address), W'(x.addr));
                chk("mem_alu_v", bus.mem_alu_v, x.alu_v);
                chk("mem_rd2_v", bus.mem_rd2_v, x.rd2_v);
                chk("mem_ctl_scalars",
                    W'({bus.mem_op_type, bus.mem_op_source, bus.mem_alu_s, bus.mem_rd2_s}),
                    W'({x.op, x.src, x.alu_s, x.rd2_s}));
                chk("ex_ready_busy", W'(bus.ex_ready), W'(1'b0));
                if (x.d != 0 && c == t + 1 + x.d) begin
                    bus.mem_finished = 1'b1;
                    bus.mem_scalar   = x.ms;
                    bus.mem_vector   = x.mv;
                end else begin
                    bus.mem_finished = x.stale && (c == t + 1);
                    bus.mem_scalar   = L'($urandom);
                    bus.mem_vector   = rand_w();
                end
                @(negedge clk);
            end
            bus.mem_finished = 1'b0;
        end
        // Retire cycle: DONE
        chk("ex_ready_done", W'(bus.ex_ready), W'(1'b0));
        chk("mem_we_done", W'(bus.mem_write_enable), W'(1'b0));
        chk("mem_rst_done", W'(bus.mem_rst), W'(1'b0));
        @(negedge clk);
        chk("ex_ready_back", W'(bus.ex_ready), W'(1'b1));
        chk("err_timeout", W'(bus.err_timeout), W'(exp_err));
    endtask

    // Monitor: pop expected packet on every retire, check hold otherwise
    exp_t mon_e;
    logic           last_en = 1'b0;
    logic [R-1:0]   last_rd = '0;
    logic           last_vec = 1'b0;
    logic [L-1:0]   last_s = '0;
    logic [W-1:0]   last_v = '0;
    logic           last_err = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            last_en = 1'b0; last_rd = '0; last_vec = 1'b0;
            last_s = '0; last_v = '0; last_err = 1'b0;
        end else if (bus.wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected at cycle %0d: actual wb_valid 1 required 0", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_cycle", W'(cyc), W'(mon_e.cyc));
                chk("wb_en", W'(bus.wb_en), W'(mon_e.en));
                chk("wb_rd", W'(bus.wb_rd), W'(mon_e.rd));
                chk("wb_vec", W'(bus.wb_vec), W'(mon_e.vec));
                chk("wb_error", W'(bus.wb_error), W'(mon_e.err));
                if (mon_e.vec) chk("wb_vector", bus.wb_vector, mon_e.v);
                else           chk("wb_scalar", W'(bus.wb_scalar), W'(mon_e.s));
                last_en = mon_e.en; last_rd = mon_e.rd; last_vec = mon_e.vec;
                last_s = mon_e.s; last_v = mon_e.v; last_err = mon_e.err;
            end
        end else begin
            chk("wb_hold_ctl", W'({bus.wb_en, bus.wb_rd, bus.wb_vec, bus.wb_error}),
                W'({last_en, last_rd, last_vec, last_err}));
            if (last_vec) chk("wb_hold_vector", bus.wb_vector, last_v);
            else          chk("wb_hold_scalar", W'(bus.wb_scalar), W'(last_s));
        end
    end

    instr_t x;
    int t0;
    bit ok;

    initial begin
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        drive_ex(rand_instr());
        bus.mem_finished = 1'b0;
        bus.mem_scalar   = '0;
        bus.mem_vector   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_rst", W'(bus.mem_rst), W'(1'b1));
        chk("rst_ex_ready", W'(bus.ex_ready), W'(1'b0));
        chk("rst_outputs", W'({bus.wb_valid, bus.err_timeout, bus.mem_write_enable, bus.wb_rd, bus.mem_address}), W'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", W'(bus.ex_ready), W'(1'b1));
        chk("post_rst_mem_rst", W'(bus.mem_rst), W'(1'b0));

        // Non-memory scalar
        x = rand_instr(); x.mem_req = 1'b0; x.op = 2'b00; x.alu_s = 8'h5A; x.rd = 5'd3; x.wb_en = 1'b1;
        issue(x);
        // Non-memory vector
        x = rand_instr(); x.mem_req = 1'b0; x.op = 2'b10; x.wb_en = 1'b1;
        issue(x);
        // Scalar load, finish on 4th ACCESS cycle
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.op = 2'b00; x.addr = 32'h10;
        x.d = 4; x.stale = 1'b0; x.ms = 8'hC3; x.wb_en = 1'b1;
        issue(x);
        // Vector store from ALU, item i = i, finish after 20 ACCESS cycles
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b1; x.op = 2'b10; x.src = 1'b1;
        for (int i = 0; i < I; i++) x.alu_v[i*L +: L] = L'(i);
        x.d = 20; x.stale = 1'b0; x.wb_en = 1'b1;
        issue(x);
        // Stale finish held through CLEAR
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.d = 1; x.stale = 1'b1; x.wb_en = 1'b1;
        issue(x);
        // Timeout, then normal completion
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.op = 2'b10; x.d = 0; x.stale = 1'b0; x.wb_en = 1'b1;
        issue(x);
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.d = 3; x.stale = 1'b0; x.wb_en = 1'b1;
        issue(x);
        // Finish on the last allowed cycle wins over timeout
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.d = TIMEOUT; x.stale = 1'b0; x.wb_en = 1'b1;
        issue(x);

        for (int n = 0; n < 40; n++) issue(rand_instr());

        // Reset on the 3rd ACCESS cycle abandons the access
        x = rand_instr(); x.mem_req = 1'b1; x.d = 0; x.stale = 1'b0;
        wait_ready(ok);
        if (ok) begin
            t0 = cyc;
            drive_ex(x);
            bus.ex_valid = 1'b1;
            bus.mem_finished = 1'b0;
            @(negedge clk);
            bus.ex_valid = 1'b0;
            while (cyc < t0 + 4) @(negedge clk);
            rst = 1'b1;
            exp_err = 1'b0;
            @(negedge clk);
            chk("mid_rst_mem_rst", W'(bus.mem_rst), W'(1'b1));
            chk("mid_rst_ex_ready", W'(bus.ex_ready), W'(1'b0));
            chk("mid_rst_ctl", W'({bus.wb_valid, bus.wb_en, bus.wb_rd, bus.err_timeout, bus.mem_write_enable, bus.mem_op_type}), W'(0));
            chk("mid_rst_addr", W'(bus.mem_address), W'(0));
            chk("mid_rst_alu_v", bus.mem_alu_v, W'(0));
            chk("mid_rst_wb_vector", bus.wb_vector, W'(0));
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("after_rst_ready", W'(bus.ex_ready), W'(1'b1));
            chk("after_rst_mem_rst", W'(bus.mem_rst), W'(1'b0));
        end

        x = rand_instr(); x.mem_req = 1'b0; x.wb_en = 1'b1;
        issue(x);
        x = rand_instr(); x.mem_req = 1'b1; x.write = 1'b0; x.d = 2; x.stale = 1'b0;
        issue(x);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(sb_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
